// File: rtl/vx_barrier_table_pkg.sv
// Shared types and helpers for the warp barrier table.
//
// Contents:
//   idx_w()          index width for an N-entry space, never below one bit
//   BT_NUM_WARPS     default warps per core
//   BT_NUM_BARRIERS  default number of concurrent barrier entries
//   barrier_req_t    barrier arrival record {wid, id, size_m1, arrive_only}
//   barrier_rel_t    barrier release record {valid, id, wmask}
//   BARRIER_REQ_W / BARRIER_REL_W  packed widths of the two records
//   req_kind_t       classification of the request seen in the current cycle
package vx_barrier_table_pkg;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int BT_NUM_WARPS    = 8;
   localparam int BT_NUM_BARRIERS = 4;
   localparam int BT_NW           = idx_w(BT_NUM_WARPS);
   localparam int BT_NB           = idx_w(BT_NUM_BARRIERS);

   typedef struct packed {
      logic [BT_NW-1:0] wid;
      logic [BT_NB-1:0] id;
      logic [BT_NW-1:0] size_m1;
      logic             arrive_only;
   } barrier_req_t;

   typedef struct packed {
      logic                    valid;
      logic [BT_NB-1:0]        id;
      logic [BT_NUM_WARPS-1:0] wmask;
   } barrier_rel_t;

   localparam int BARRIER_REQ_W = $bits(barrier_req_t);
   localparam int BARRIER_REL_W = $bits(barrier_rel_t);

   // What the accepted request does to its entry this cycle.
   typedef enum logic [2:0] {
      REQ_IDLE    = 3'd0,  // no accepted request
      REQ_OPEN    = 3'd1,  // first arrival on an invalid entry
      REQ_COUNT   = 3'd2,  // arrival counted, barrier still open
      REQ_RELEASE = 3'd3,  // last participant arrived
      REQ_DROP    = 3'd4   // duplicate warp or out-of-range id
   } req_kind_t;

endpackage

// File: rtl/vx_barrier_table_entry.sv
// One barrier entry: participant size, arrival count and blocking-warp mask.
//
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   arrive       accepted request addressed to this entry (one-cycle strobe)
//   wid          arriving warp
//   size_m1      requested participant count minus one
//   blocking     arrival stalls the warp (not arrive-only)
//   flush        remove flush_wid from this entry (one-cycle strobe)
//   flush_wid    warp being removed
//   valid        entry holds an open barrier
//   complete     this arrival is the last one (combinational)
//   dup          arriving warp is already waiting here (combinational)
//   size_err     arrival size disagrees with the stored size (combinational)
//   wmask        warps currently stalled on this entry
//   rel_wmask    mask to release if complete is high
module vx_barrier_table_entry
   import vx_barrier_table_pkg::*;
#(
   parameter int NUM_WARPS = BT_NUM_WARPS,
   parameter int NW        = idx_w(NUM_WARPS)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 arrive,
   input  logic [NW-1:0]        wid,
   input  logic [NW-1:0]        size_m1,
   input  logic                 blocking,
   input  logic                 flush,
   input  logic [NW-1:0]        flush_wid,
   output logic                 valid,
   output logic                 complete,
   output logic                 dup,
   output logic                 size_err,
   output logic [NUM_WARPS-1:0] wmask,
   output logic [NUM_WARPS-1:0] rel_wmask
);

   logic                 valid_q;
   logic [NW-1:0]        size_q;
   logic [NW-1:0]        count_q;
   logic [NUM_WARPS-1:0] wmask_q;

   logic [NUM_WARPS-1:0] wid_bit;
   logic [NUM_WARPS-1:0] flush_bit;
   logic [NW-1:0]        eff_size;
   logic                 flush_hit;
   logic [NUM_WARPS-1:0] flush_mask;
   logic [NW-1:0]        flush_count;

   assign wid_bit   = NUM_WARPS'(1) << wid;
   assign flush_bit = NUM_WARPS'(1) << flush_wid;

   // An open entry keeps the size latched by its first arrival.
   assign eff_size  = valid_q ? size_q : size_m1;

   assign dup       = arrive && ((wmask_q & wid_bit) != '0);
   assign size_err  = arrive && valid_q && (size_m1 != size_q);
   assign complete  = arrive && !dup && (count_q == eff_size);
   assign rel_wmask = wmask_q | (blocking ? wid_bit : '0);

   // A set wmask bit always stands for a counted arrival, so count >= 1 here.
   assign flush_hit   = flush && ((wmask_q & flush_bit) != '0);
   assign flush_mask  = wmask_q & ~flush_bit;
   assign flush_count = count_q - NW'(1);

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= 1'b0;
         size_q  <= '0;
         count_q <= '0;
         wmask_q <= '0;
      end else if (complete) begin
         valid_q <= 1'b0;
         size_q  <= '0;
         count_q <= '0;
         wmask_q <= '0;
      end else if (arrive && !dup) begin
         valid_q <= 1'b1;
         size_q  <= eff_size;
         count_q <= count_q + NW'(1);
         wmask_q <= rel_wmask;
      end else if (flush_hit) begin
         wmask_q <= flush_mask;
         count_q <= flush_count;
         if ((flush_count == '0) && (flush_mask == '0)) begin
            valid_q <= 1'b0;
            size_q  <= '0;
         end
      end
   end

   assign valid = valid_q;
   assign wmask = wmask_q;

endmodule

// File: rtl/vx_barrier_table.sv
// Multi-entry warp barrier tracker for one core.
//
// Handshake: a request is taken on a cycle where req_valid && req_ready.
// req_ready is simply !flush_valid, so a flush and a request never act in
// the same cycle; the requester holds its request until it is taken.
//
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   req_valid/ready  barrier arrival handshake
//   req_wid          arriving warp
//   req_id           barrier entry
//   req_size_m1      participant count minus one
//   req_arrive_only  count the arrival without stalling the warp
//   flush_valid      remove flush_wid from every barrier (warp kill)
//   flush_wid        warp to remove
//   rel_valid        one-cycle registered release pulse
//   rel_id           released barrier
//   rel_wmask        warps to unstall
//   stalled_wmask    OR of all entry wait masks
//   err              sticky protocol error (duplicate, size mismatch, bad id)
module vx_barrier_table
   import vx_barrier_table_pkg::*;
#(
   parameter  int NUM_WARPS    = BT_NUM_WARPS,
   parameter  int NUM_BARRIERS = BT_NUM_BARRIERS,
   localparam int NW           = idx_w(NUM_WARPS),
   localparam int NB           = idx_w(NUM_BARRIERS)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [NW-1:0]        req_wid,
   input  logic [NB-1:0]        req_id,
   input  logic [NW-1:0]        req_size_m1,
   input  logic                 req_arrive_only,
   input  logic                 flush_valid,
   input  logic [NW-1:0]        flush_wid,
   output logic                 rel_valid,
   output logic [NB-1:0]        rel_id,
   output logic [NUM_WARPS-1:0] rel_wmask,
   output logic [NUM_WARPS-1:0] stalled_wmask,
   output logic                 err
);

   logic                 accept;
   logic                 id_ok;
   logic                 arrive_v   [NUM_BARRIERS];
   logic                 valid_v    [NUM_BARRIERS];
   logic                 complete_v [NUM_BARRIERS];
   logic                 dup_v      [NUM_BARRIERS];
   logic                 size_err_v [NUM_BARRIERS];
   logic [NUM_WARPS-1:0] wmask_a    [NUM_BARRIERS];
   logic [NUM_WARPS-1:0] rel_a      [NUM_BARRIERS];

   logic                 any_complete;
   logic                 any_dup;
   logic                 any_err;
   logic                 sel_valid;
   logic [NUM_WARPS-1:0] sel_rel;
   logic [NUM_WARPS-1:0] stalled_c;
   req_kind_t            req_kind;

   assign req_ready = !flush_valid;
   assign accept    = req_valid && req_ready;
   // Only matters when NUM_BARRIERS is not a power of two.
   assign id_ok     = ({1'b0, req_id} < (NB+1)'(NUM_BARRIERS));

   for (genvar g = 0; g < NUM_BARRIERS; g++) begin : g_entry
      assign arrive_v[g] = accept && id_ok && (req_id == NB'(g));

      vx_barrier_table_entry #(
         .NUM_WARPS (NUM_WARPS),
         .NW        (NW)
      ) u_entry (
         .clk       (clk),
         .reset     (reset),
         .arrive    (arrive_v[g]),
         .wid       (req_wid),
         .size_m1   (req_size_m1),
         .blocking  (!req_arrive_only),
         .flush     (flush_valid),
         .flush_wid (flush_wid),
         .valid     (valid_v[g]),
         .complete  (complete_v[g]),
         .dup       (dup_v[g]),
         .size_err  (size_err_v[g]),
         .wmask     (wmask_a[g]),
         .rel_wmask (rel_a[g])
      );
   end

   // At most one entry sees an arrival, so the OR-reductions double as muxes.
   always_comb begin
      stalled_c    = '0;
      any_complete = 1'b0;
      any_dup      = 1'b0;
      any_err      = accept && !id_ok;
      sel_valid    = 1'b0;
      sel_rel      = '0;
      for (int e = 0; e < NUM_BARRIERS; e++) begin
         stalled_c = stalled_c | wmask_a[e];
         any_dup   = any_dup | dup_v[e];
         any_err   = any_err | dup_v[e] | size_err_v[e];
         if (arrive_v[e]) begin
            sel_valid = valid_v[e];
         end
         if (complete_v[e]) begin
            any_complete = 1'b1;
            sel_rel      = rel_a[e];
         end
      end
   end

   always_comb begin
      req_kind = REQ_IDLE;
      if (accept) begin
         if (!id_ok || any_dup) begin
            req_kind = REQ_DROP;
         end else if (any_complete) begin
            req_kind = REQ_RELEASE;
         end else if (!sel_valid) begin
            req_kind = REQ_OPEN;
         end else begin
            req_kind = REQ_COUNT;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rel_valid <= 1'b0;
         rel_id    <= '0;
         rel_wmask <= '0;
         err       <= 1'b0;
      end else begin
         rel_valid <= (req_kind == REQ_RELEASE);
         if (req_kind == REQ_RELEASE) begin
            rel_id    <= req_id;
            rel_wmask <= sel_rel;
         end
         err <= err | any_err;
      end
   end

   // Entry masks are registered and cleared on completion, so a releasing
   // warp has already left this mask in the cycle its release is visible.
   assign stalled_wmask = stalled_c;

endmodule

// File: tb/tb_vx_barrier_table.sv
module tb_vx_barrier_table;

   localparam int NUM_WARPS    = 4;
   localparam int NUM_BARRIERS = 4;
   localparam int NW           = 2;
   localparam int NB           = 2;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic                 req_valid = 1'b0;
   logic                 req_ready;
   logic [NW-1:0]        req_wid = '0;
   logic [NB-1:0]        req_id = '0;
   logic [NW-1:0]        req_size_m1 = '0;
   logic                 req_arrive_only = 1'b0;
   logic                 flush_valid = 1'b0;
   logic [NW-1:0]        flush_wid = '0;
   logic                 rel_valid;
   logic [NB-1:0]        rel_id;
   logic [NUM_WARPS-1:0] rel_wmask;
   logic [NUM_WARPS-1:0] stalled_wmask;
   logic                 err;

   vx_barrier_table #(
      .NUM_WARPS    (NUM_WARPS),
      .NUM_BARRIERS (NUM_BARRIERS)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .req_valid       (req_valid),
      .req_ready       (req_ready),
      .req_wid         (req_wid),
      .req_id          (req_id),
      .req_size_m1     (req_size_m1),
      .req_arrive_only (req_arrive_only),
      .flush_valid     (flush_valid),
      .flush_wid       (flush_wid),
      .rel_valid       (rel_valid),
      .rel_id          (rel_id),
      .rel_wmask       (rel_wmask),
      .stalled_wmask   (stalled_wmask),
      .err             (err)
   );

   int vectors = 0;
   int miscompares = 0;
   bit checking = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Each barrier is a bag of arrivals; it releases once size_m1+1 distinct
   // arrivals have been collected. Expected releases go to exp_q as {id, mask}.
   bit             m_valid [NUM_BARRIERS];
   int             m_size  [NUM_BARRIERS];
   int             m_arr   [NUM_BARRIERS];
   logic [3:0]     m_mask  [NUM_BARRIERS];
   logic           m_err;
   logic           m_rel_valid;
   logic [NB+NUM_WARPS-1:0] exp_q[$];

   always @(posedge clk) begin
      if (reset) begin
         for (int e = 0; e < NUM_BARRIERS; e++) begin
            m_valid[e] = 0; m_size[e] = 0; m_arr[e] = 0; m_mask[e] = '0;
         end
         m_err = 1'b0;
         m_rel_valid = 1'b0;
      end else begin
         m_rel_valid = 1'b0;
         if (flush_valid) begin
            for (int e = 0; e < NUM_BARRIERS; e++) begin
               if (m_mask[e][flush_wid]) begin
                  m_mask[e][flush_wid] = 1'b0;
                  m_arr[e] = m_arr[e] - 1;
                  if (m_arr[e] == 0 && m_mask[e] == 0) m_valid[e] = 0;
               end
            end
         end else if (req_valid) begin
            int e;
            logic [3:0] b;
            e = int'(req_id);
            b = 4'b0001 << req_wid;
            if (m_valid[e] && m_size[e] != int'(req_size_m1)) m_err = 1'b1;
            if ((m_mask[e] & b) != 0) begin
               m_err = 1'b1;
            end else begin
               if (!m_valid[e]) begin
                  m_valid[e] = 1; m_size[e] = int'(req_size_m1); m_arr[e] = 0;
               end
               if (!req_arrive_only) m_mask[e] = m_mask[e] | b;
               m_arr[e] = m_arr[e] + 1;
               if (m_arr[e] == m_size[e] + 1) begin
                  m_rel_valid = 1'b1;
                  exp_q.push_back({req_id, m_mask[e]});
                  m_valid[e] = 0; m_size[e] = 0; m_arr[e] = 0; m_mask[e] = '0;
               end
            end
         end
      end
   end

   // ---------------- compare process ----------------
   logic [3:0]              cmp_stalled;
   logic [NB+NUM_WARPS-1:0] cmp_rel;

   always @(negedge clk) begin
      if (checking) begin
         cmp_stalled = '0;
         for (int e = 0; e < NUM_BARRIERS; e++) cmp_stalled = cmp_stalled | m_mask[e];
         chk("req_ready", 32'(req_ready), 32'(!flush_valid));
         chk("rel_valid", 32'(rel_valid), 32'(m_rel_valid));
         chk("stalled_wmask", 32'(stalled_wmask), 32'(cmp_stalled));
         chk("err", 32'(err), 32'(m_err));
         if (rel_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               chk("rel_unexpected", 32'(1), 32'(0));
            end else begin
               cmp_rel = exp_q.pop_front();
               chk("rel_id", 32'(rel_id), 32'(cmp_rel[NB+NUM_WARPS-1:NUM_WARPS]));
               chk("rel_wmask", 32'(rel_wmask), 32'(cmp_rel[NUM_WARPS-1:0]));
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   // Inputs change 1 time unit after a rising edge; outputs read there are
   // the registered result of the edge just passed.
   task automatic do_req(input int wid, input int id, input int size_m1, input bit ao);
      req_valid = 1'b1;
      req_wid = NW'(wid);
      req_id = NB'(id);
      req_size_m1 = NW'(size_m1);
      req_arrive_only = ao;
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_arrive_only = 1'b0;
   endtask

   // A request is held up alongside the flush; it must not be taken.
   task automatic do_flush(input int wid);
      flush_valid = 1'b1;
      flush_wid = NW'(wid);
      req_valid = 1'b1;
      req_wid = 2'd2;
      req_id = 2'd1;
      req_size_m1 = 2'd2;
      #1;
      chk("ready_during_flush", 32'(req_ready), 32'(0));
      @(posedge clk); #1;
      flush_valid = 1'b0;
      req_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic chk_rel(input string name, input int id, input int mask);
      chk({name, "_valid"}, 32'(rel_valid), 32'(1));
      chk({name, "_id"}, 32'(rel_id), 32'(id));
      chk({name, "_wmask"}, 32'(rel_wmask), 32'(mask));
   endtask

   // ---------------- directed stimulus ----------------
   initial begin
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      checking = 1'b1;

      chk("rst_rel_valid", 32'(rel_valid), 32'(0));
      chk("rst_rel_id", 32'(rel_id), 32'(0));
      chk("rst_rel_wmask", 32'(rel_wmask), 32'(0));
      chk("rst_stalled", 32'(stalled_wmask), 32'(0));
      chk("rst_err", 32'(err), 32'(0));
      chk("rst_ready", 32'(req_ready), 32'(1));

      // Three blocking arrivals, size 3, id 1.
      do_req(0, 1, 2, 0);
      chk("seq_stalled_w0", 32'(stalled_wmask), 32'(4'b0001));
      chk("seq_no_rel_w0", 32'(rel_valid), 32'(0));
      do_req(1, 1, 2, 0);
      chk("seq_stalled_w1", 32'(stalled_wmask), 32'(4'b0011));
      do_req(2, 1, 2, 0);
      chk_rel("seq_rel", 1, 4'b0111);
      chk("seq_stalled_rel", 32'(stalled_wmask), 32'(0));
      idle(1);
      chk("seq_pulse_one_cycle", 32'(rel_valid), 32'(0));

      // Single-participant barrier releases at once.
      do_req(3, 0, 0, 0);
      chk_rel("solo_rel", 0, 4'b1000);
      chk("solo_stalled", 32'(stalled_wmask), 32'(0));

      // Arrive-only participant is counted but never stalled.
      do_req(0, 2, 1, 1);
      chk("ao_stalled", 32'(stalled_wmask), 32'(0));
      chk("ao_no_rel", 32'(rel_valid), 32'(0));
      do_req(1, 2, 1, 0);
      chk_rel("ao_rel", 2, 4'b0010);

      // Same warp waiting on two barriers, then killed.
      do_req(0, 0, 1, 0);
      do_req(0, 3, 1, 0);
      chk("two_bar_stalled", 32'(stalled_wmask), 32'(4'b0001));
      chk("two_bar_err", 32'(err), 32'(0));
      do_flush(0);
      chk("flush_stalled", 32'(stalled_wmask), 32'(0));
      chk("flush_no_rel", 32'(rel_valid), 32'(0));
      do_req(1, 0, 1, 0);
      chk("flush_fresh_no_rel", 32'(rel_valid), 32'(0));
      chk("flush_fresh_stalled", 32'(stalled_wmask), 32'(4'b0010));
      do_req(2, 0, 1, 0);
      chk_rel("flush_fresh_rel", 0, 4'b0110);
      // Entry 3 must be free again: a new size latches without error.
      do_req(1, 3, 2, 0);
      chk("flush_e3_free_err", 32'(err), 32'(0));
      do_req(2, 3, 2, 0);
      do_req(3, 3, 2, 0);
      chk_rel("e3_rel", 3, 4'b1110);

      // Duplicate arrival and size mismatch.
      do_req(2, 1, 2, 0);
      chk("dup_first_stalled", 32'(stalled_wmask), 32'(4'b0100));
      do_req(2, 1, 2, 0);
      chk("dup_err", 32'(err), 32'(1));
      chk("dup_stalled", 32'(stalled_wmask), 32'(4'b0100));
      do_req(3, 1, 3, 0);
      chk("mismatch_no_rel", 32'(rel_valid), 32'(0));
      chk("mismatch_stalled", 32'(stalled_wmask), 32'(4'b1100));
      do_req(0, 1, 2, 0);
      chk_rel("dup_rel", 1, 4'b1101);
      idle(2);
      chk("err_sticky", 32'(err), 32'(1));

      // Reset in the middle of a barrier.
      do_req(0, 1, 2, 0);
      do_req(1, 1, 2, 0);
      chk("pre_reset_stalled", 32'(stalled_wmask), 32'(4'b0011));
      pulse_reset();
      chk("mid_rst_rel_valid", 32'(rel_valid), 32'(0));
      chk("mid_rst_stalled", 32'(stalled_wmask), 32'(0));
      chk("mid_rst_err", 32'(err), 32'(0));
      chk("mid_rst_rel_wmask", 32'(rel_wmask), 32'(0));
      do_req(0, 1, 2, 0);
      do_req(1, 1, 2, 0);
      do_req(2, 1, 2, 0);
      chk_rel("post_rst_rel", 1, 4'b0111);

      // Back-to-back releases on consecutive cycles.
      do_req(0, 0, 0, 0);
      chk_rel("b2b_rel0", 0, 4'b0001);
      do_req(1, 2, 0, 1);
      chk_rel("b2b_rel1", 2, 4'b0000);

      idle(3);
      chk("rel_queue_empty", 32'(exp_q.size()), 32'(0));
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
